// File: rtl/uart8_tx_fifo.sv
// Byte FIFO that feeds an 8-bit UART transmitter through a level-held txStart/txBusy handshake.
// Define UART8_TX_FIFO_SYNC_EN to pass txBusy through a 2-flop synchronizer when the transmitter clock is asynchronous.
module uart8_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  en,
  input  logic                  wrEn,
  input  logic [7:0]            wrData,
  input  logic                  clrOvf,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  txStart,
  output logic [7:0]            txData,
  input  logic                  txBusy,
  output logic [1:0]            o_dbg_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wp;
  logic [DEPTH_LOG2-1:0] r_rp;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;
  logic [7:0]            r_tx_data;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr;
  logic                  w_drop;
  logic                  w_pop;
  logic                  w_busy;

`ifdef UART8_TX_FIFO_SYNC_EN
  logic r_busy_s1;
  logic r_busy_s2;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_busy_s1 <= 1'b0;
      r_busy_s2 <= 1'b0;
    end else begin
      r_busy_s1 <= txBusy;
      r_busy_s2 <= r_busy_s1;
    end
  end

  assign w_busy = r_busy_s2;
`else
  assign w_busy = txBusy;
`endif

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  // Full is judged on the pre-edge count, so a same-cycle pop never rescues a write.
  assign w_wr    = wrEn && !w_full;
  assign w_drop  = wrEn && w_full;

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en && !w_empty) begin
          w_pop  = 1'b1;
          w_next = S_START;
        end
      end
      S_START: if (w_busy) w_next = S_WAIT;
      S_WAIT:  if (!w_busy) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state    <= S_IDLE;
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_state <= w_next;
      if (w_wr) r_wp <= r_wp + DEPTH_LOG2'(1);
      if (w_pop) begin
        r_rp      <= r_rp + DEPTH_LOG2'(1);
        r_tx_data <= r_mem[r_rp];
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (DEPTH_LOG2+1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_LOG2+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop)      r_overflow <= 1'b1;
      else if (clrOvf) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= wrData;
  end

  assign full        = w_full;
  assign empty       = w_empty;
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign txStart     = (r_state == S_START);
  assign txData      = r_tx_data;
  assign o_dbg_state = r_state;

endmodule

// File: doc/uart8_tx_fifo.md
# uart8_tx_fifo

Byte-buffering stage directly upstream of the 8-bit UART transmit path. Accepts bytes from the system-side writer into a circular FIFO. Drains them one at a time into the UART transmitter through its `txStart` / `in` / `txBusy` handshake. Lets software burst up to DEPTH bytes without waiting on the serial line.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 entries of 8 bits. Legal range is 1..8.
- `clk` input 1: system clock (the same `clk` that feeds the UART top).
- `rstN` input 1: reset, synchronous, active-low.
- `en` input 1: drain enable. When low, no new byte is launched. Writes are still accepted.
- `wrEn` input 1: write strobe, one byte per cycle.
- `wrData` input 8: byte to enqueue.
- `clrOvf` input 1: clears the sticky `overflow` flag.
- `full` output 1: count == 2^DEPTH_LOG2.
- `empty` output 1: count == 0.
- `count` output DEPTH_LOG2+1: current occupancy.
- `overflow` output 1: sticky flag. Set when a write is dropped.
- `txStart` output 1: start request to the transmitter.
- `txData` output 8: byte presented to the transmitter's `in`.
- `txBusy` input 1: transmitter busy, from the UART's tx clock domain.

## Operation
- **Storage:** 2^DEPTH_LOG2 x 8 register array.
  - Write pointer `wp` and read pointer `rp`, each DEPTH_LOG2 bits. Both wrap modulo depth.
  - `count` is tracked separately, so `full` and `empty` are unambiguous.
- **Write:** when `wrEn` is high and `full` is low (using the pre-edge value), `wrData` is stored at `wp` and `wp` increments.
  - When `wrEn` is high and `full` is high, the byte is dropped, `overflow` is set, and pointers are unchanged.
- **Overflow priority:** if `clrOvf` and a dropped write occur in the same cycle, the set wins.
- **Pop:** performed only by the FSM in IDLE. It registers `mem[rp]` into `txData` and increments `rp`.
- **Simultaneous write and pop:** `count` is unchanged. A write while `full` is dropped even if a pop occurs in the same cycle.
- **FSM states:**
  - IDLE: if `en` is high and `empty` is low, pop the byte and go to START.
  - START: `txStart` = 1. Stay until the sampled `txBusy` = 1, then go to WAIT.
  - WAIT: `txStart` = 0. Stay until the sampled `txBusy` = 0, then go to IDLE.
- **Handshake across domains:** `txStart` is a level held until busy is observed. This is required because the transmitter runs on a slower divided clock.
- **`txData` stability:** `txData` holds its value from the pop until the next pop.
- **`en` deassertion:** dropping `en` in START or WAIT does not abort. The byte in flight completes.

## Timing
- **Reset values:** `full` = 0, `empty` = 1, `count` = 0, `overflow` = 0, `txStart` = 0, `txData` = 0. FSM is in IDLE and both pointers are 0.
- **Reset mid-operation:** the FIFO is flushed and `txStart` drops at the reset edge. A transmitter already busy finishes its frame unaffected.
- **Status update:** `count`, `full` and `empty` update on the edge after the write.
- **Latency from an empty FIFO:** write accepted at edge 0, `empty` falls after edge 0, pop at edge 1, `txStart` = 1 and `txData` valid after edge 1.
- **Back-to-back bytes:** the next pop occurs one cycle after the sampled `txBusy` falls. There are no gaps beyond this.
- **Wrap:** after 2^DEPTH_LOG2 writes, `wp` returns to 0 with no special-case behaviour.

## Configuration
- **`UART8_TX_FIFO_SYNC_EN` defined:** `txBusy` passes through a 2-flop synchronizer before the FSM samples it. This adds 2 cycles to each busy-edge detection.
- **`UART8_TX_FIFO_SYNC_EN` undefined:** `txBusy` is sampled directly. Use only when the transmitter is clocked synchronously to `clk`.

## Test plan
- **Single byte:** reset, `en` = 1, write 0xA5. `txStart` rises 2 cycles later with `txData` = 0xA5. `txStart` holds until `txBusy` = 1 is sampled, then falls. `empty` = 1.
- **Fill and overflow:** with `en` = 0 and DEPTH_LOG2 = 2, write 0x01..0x05.
  - `full` = 1 after the 4th write and `count` = 4.
  - The 5th write is dropped and `overflow` = 1.
  - `clrOvf` clears `overflow`.
- **Ordering and wrap:** with `en` = 1 and a transmitter model that is busy for 10 cycles per byte, write 0x10..0x17 (8 bytes, DEPTH_LOG2 = 2, paced so nothing drops). `txData` sequence is 0x10..0x17 in order and pointers wrap twice.
- **Full with pop:** FIFO full in the cycle where IDLE pops and `wrEn` = 1 with 0xEE. The byte is dropped, `overflow` = 1, `count` = 3.
- **Reset mid-transfer:** `rstN` = 0 during START with 3 bytes queued. Next cycle `txStart` = 0, `count` = 0, `empty` = 1. After release with `en` = 1, nothing is sent.
- **Sync macro:** with `UART8_TX_FIFO_SYNC_EN` defined, `txBusy` rise → START exits exactly 2 cycles later than in the undefined build.
